layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NU_COUNT, default 4, the number of neural-unit lanes per group.
REQ-002 SHALL have parameter ADDR_W, default 12, the XY/W memory address width.
REQ-003 SHALL have parameter ACC_LAT, default 2, the drain cycles between the last read and the accumulator results being valid.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begins a layer; sampled only in IDLE.
REQ-007 SHALL have ports in_count and out_count, input, ADDR_W each: inputs per neuron N and neurons per layer M.
REQ-008 SHALL have ports x_base, y_base and w_base, input, ADDR_W each: base addresses of input vector, output vector and weights.
REQ-009 SHALL have port xy_rd_addr, output, ADDR_W: input-vector read address.
REQ-010 SHALL have port w_rd_addr, output, ADDR_W: weight read address; one word holds NU_COUNT lane weights.
REQ-011 SHALL have port mem_rd_en, output, 1 bit: XY/W read strobe.
REQ-012 SHALL have port nu_clear, output, 1 bit: clear all NU accumulators.
REQ-013 SHALL have port nu_acc_en, output, 1 bit: NU multiply-accumulate enable.
REQ-014 SHALL have port nu_mask, output, NU_COUNT bits: lanes active in the current group.
REQ-015 SHALL have port out_sel, output, clog2(NU_COUNT) bits: lane routed to the activation/write path.
REQ-016 SHALL have ports y_wr_en (output, 1 bit), y_wr_addr (output, ADDR_W) and y_wr_ready (input, 1 bit): output write handshake.
REQ-017 SHALL have ports busy (output, 1 bit), done (output, 1 bit, one-cycle pulse) and cycle_count (output, 32 bits).

Function
REQ-018 SHALL latch N, M and all three bases on an accepted start and ignore input changes until IDLE.
REQ-019 SHALL implement states IDLE, CLEAR, ACC, DRAIN, WRITE, DONE.
REQ-020 SHALL, in IDLE with start=1 and N!=0 and M!=0, go to CLEAR; with N=0 or M=0 it SHALL go directly to DONE with no memory or NU activity.
REQ-021 SHALL, in CLEAR, assert nu_clear for exactly one cycle, reset the input index i to 0, and go to ACC.
REQ-022 SHALL, in ACC, assert mem_rd_en with xy_rd_addr=x_base+i and w_rd_addr=w_ptr, then increment i and w_ptr each cycle; after i=N-1 it SHALL go to DRAIN.
REQ-023 SHALL drive nu_acc_en as mem_rd_en delayed by one cycle, matching the 1-cycle memory read latency.
REQ-024 SHALL stay in DRAIN for ACC_LAT cycles, then go to WRITE.
REQ-025 SHALL set w_ptr to w_base at start and never reset it between groups, so group g, input i reads w_base+g*N+i.
REQ-026 SHALL, in WRITE, step lane k from 0 to L-1 with L=min(NU_COUNT, M-g*NU_COUNT), driving out_sel=k, y_wr_en=1 and y_wr_addr=y_base+g*NU_COUNT+k.
REQ-027 SHALL advance k only when y_wr_ready=1 and hold all WRITE outputs stable while it is 0.
REQ-028 SHALL, after the last lane write is accepted, go to CLEAR if groups remain, else to DONE.
REQ-029 SHALL drive nu_mask with the low L bits set for the current group.
REQ-030 SHALL wrap all address arithmetic modulo 2^ADDR_W.
REQ-031 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-032 SHALL hold busy=1 in every state except IDLE.
REQ-033 SHALL ignore start while busy=1.

Reset
REQ-034 SHALL, while rst_n=0 (including mid-operation), go to IDLE immediately and drive every output to 0; any layer in progress is abandoned.

Configuration
REQ-035 SHALL, with SEQ_PERF_CNT_EN defined, clear cycle_count on an accepted start, increment it every busy cycle, and hold it after done.
REQ-036 SHALL, without SEQ_PERF_CNT_EN, keep the cycle_count port present and tie it to 0.

Verification
REQ-037 SHALL cover: N=3, M=4, all bases 0, ready=1 -> reads addr 0..2, writes y 0..3 with out_sel 0..3, done in the 11th cycle after start, cycle_count=11 with the macro defined.
REQ-038 SHALL cover: N=2, M=5 -> second group has nu_mask=0001, w_rd_addr 2..3, a single write to y_base+4.
REQ-039 SHALL cover: y_wr_ready=0 for 3 cycles on lane 1 -> out_sel, y_wr_addr and y_wr_en held, no lane skipped.
REQ-040 SHALL cover: start pulse during ACC -> ignored, no restart; N=0 -> done one cycle after start, with no mem_rd_en or nu_clear.
REQ-041 SHALL cover: x_base=0xFFE, N=4 -> xy_rd_addr sequence FFE, FFF, 000, 001.
REQ-042 SHALL cover: rst_n low during WRITE -> all outputs 0 asynchronously; after release, a new start runs a full layer correctly.

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks inputs and weights for groups of NU_COUNT neural units, then writes the group results.
// Optional feature: define SEQ_PERF_CNT_EN to enable the busy-cycle counter on cycle_count.
module layer_sequencer #(
  parameter int NU_COUNT = 4,
  parameter int ADDR_W   = 12,
  parameter int ACC_LAT  = 2,
  localparam int SEL_W   = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   in_count,
  input  logic [ADDR_W-1:0]   out_count,
  input  logic [ADDR_W-1:0]   x_base,
  input  logic [ADDR_W-1:0]   y_base,
  input  logic [ADDR_W-1:0]   w_base,
  output logic [ADDR_W-1:0]   xy_rd_addr,
  output logic [ADDR_W-1:0]   w_rd_addr,
  output logic                mem_rd_en,
  output logic                nu_clear,
  output logic                nu_acc_en,
  output logic [NU_COUNT-1:0] nu_mask,
  output logic [SEL_W-1:0]    out_sel,
  output logic                y_wr_en,
  output logic [ADDR_W-1:0]   y_wr_addr,
  input  logic                y_wr_ready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         cycle_count
);

  localparam int LW = $clog2(NU_COUNT + 1);
  localparam int DW = $clog2(ACC_LAT + 2);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACC, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] n_r;
  logic [ADDR_W-1:0] rem_r;
  logic [ADDR_W-1:0] x_base_r;
  logic [ADDR_W-1:0] y_ptr_r;
  logic [ADDR_W-1:0] w_ptr_r;
  logic [ADDR_W-1:0] i_r;
  logic [DW-1:0]     drain_r;
  logic [LW-1:0]     len_r;

  // Lanes used by a group given the neurons still outstanding.
  function automatic logic [LW-1:0] lane_len(input logic [ADDR_W-1:0] rem);
    if (rem >= ADDR_W'(NU_COUNT)) begin
      lane_len = LW'(NU_COUNT);
    end else begin
      lane_len = rem[LW-1:0];
    end
  endfunction

  function automatic logic [NU_COUNT-1:0] lane_mask(input logic [LW-1:0] len);
    for (int j = 0; j < NU_COUNT; j++) begin
      lane_mask[j] = (j < int'(len));
    end
  endfunction

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      n_r        <= '0;
      rem_r      <= '0;
      x_base_r   <= '0;
      y_ptr_r    <= '0;
      w_ptr_r    <= '0;
      i_r        <= '0;
      drain_r    <= '0;
      len_r      <= '0;
      xy_rd_addr <= '0;
      w_rd_addr  <= '0;
      mem_rd_en  <= 1'b0;
      nu_clear   <= 1'b0;
      nu_acc_en  <= 1'b0;
      nu_mask    <= '0;
      out_sel    <= '0;
      y_wr_en    <= 1'b0;
      y_wr_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      nu_acc_en <= mem_rd_en;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            n_r      <= in_count;
            rem_r    <= out_count;
            x_base_r <= x_base;
            y_ptr_r  <= y_base;
            w_ptr_r  <= w_base;
            busy     <= 1'b1;
            if ((in_count == '0) || (out_count == '0)) begin
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              nu_clear <= 1'b1;
              len_r    <= lane_len(out_count);
              nu_mask  <= lane_mask(lane_len(out_count));
              state_r  <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          nu_clear   <= 1'b0;
          mem_rd_en  <= 1'b1;
          xy_rd_addr <= x_base_r;
          w_rd_addr  <= w_ptr_r;
          w_ptr_r    <= w_ptr_r + ADDR_W'(1);
          i_r        <= '0;
          state_r    <= S_ACC;
        end
        S_ACC: begin
          if (i_r == n_r - ADDR_W'(1)) begin
            mem_rd_en <= 1'b0;
            if (ACC_LAT == 0) begin
              y_wr_en   <= 1'b1;
              out_sel   <= '0;
              y_wr_addr <= y_ptr_r;
              state_r   <= S_WRITE;
            end else begin
              drain_r <= '0;
              state_r <= S_DRAIN;
            end
          end else begin
            i_r        <= i_r + ADDR_W'(1);
            xy_rd_addr <= xy_rd_addr + ADDR_W'(1);
            w_rd_addr  <= w_ptr_r;
            w_ptr_r    <= w_ptr_r + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_r == DW'(ACC_LAT - 1)) begin
            y_wr_en   <= 1'b1;
            out_sel   <= '0;
            y_wr_addr <= y_ptr_r;
            state_r   <= S_WRITE;
          end else begin
            drain_r <= drain_r + DW'(1);
          end
        end
        S_WRITE: begin
          // Outputs hold untouched while the write port stalls.
          if (y_wr_ready) begin
            y_ptr_r <= y_ptr_r + ADDR_W'(1);
            if (LW'(out_sel) == len_r - LW'(1)) begin
              y_wr_en <= 1'b0;
              out_sel <= '0;
              if (rem_r > ADDR_W'(NU_COUNT)) begin
                rem_r    <= rem_r - ADDR_W'(NU_COUNT);
                len_r    <= lane_len(rem_r - ADDR_W'(NU_COUNT));
                nu_mask  <= lane_mask(lane_len(rem_r - ADDR_W'(NU_COUNT)));
                nu_clear <= 1'b1;
                state_r  <= S_CLEAR;
              end else begin
                nu_mask <= '0;
                done    <= 1'b1;
                state_r <= S_DONE;
              end
            end else begin
              out_sel   <= out_sel + SEL_W'(1);
              y_wr_addr <= y_wr_addr + ADDR_W'(1);
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          mem_rd_en <= 1'b0;
          nu_clear  <= 1'b0;
          y_wr_en   <= 1'b0;
          nu_mask   <= '0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count_r;

  // Busy-cycle counter, restarted by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_r <= 32'd0;
    end else if ((state_r == S_IDLE) && start) begin
      cycle_count_r <= 32'd0;
    end else if (busy) begin
      cycle_count_r <= cycle_count_r + 32'd1;
    end
  end

  assign cycle_count = cycle_count_r;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a per-layer reference model fills expectation queues, a monitor drains them.
module tb_layer_sequencer;
  localparam int NU = 4;
  localparam int AW = 12;
  localparam int AL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] in_count = '0, out_count = '0, x_base = '0, y_base = '0, w_base = '0;
  logic [AW-1:0] xy_rd_addr, w_rd_addr, y_wr_addr;
  logic          mem_rd_en, nu_clear, nu_acc_en, y_wr_en, busy, done;
  logic [NU-1:0] nu_mask;
  logic [1:0]    out_sel;
  logic          y_wr_ready = 1'b1;
  logic [31:0]   cycle_count;

  layer_sequencer #(.NU_COUNT(NU), .ADDR_W(AW), .ACC_LAT(AL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_count(in_count), .out_count(out_count),
    .x_base(x_base), .y_base(y_base), .w_base(w_base), .xy_rd_addr(xy_rd_addr),
    .w_rd_addr(w_rd_addr), .mem_rd_en(mem_rd_en), .nu_clear(nu_clear), .nu_acc_en(nu_acc_en),
    .nu_mask(nu_mask), .out_sel(out_sel), .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr),
    .y_wr_ready(y_wr_ready), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] xa; logic [AW-1:0] wa; logic [NU-1:0] m;} rd_t;
  typedef struct {logic [AW-1:0] ya; logic [1:0] sel; logic [NU-1:0] m;} wr_t;

  rd_t           rd_q[$];
  wr_t           wr_q[$];
  logic [NU-1:0] clr_q[$];
  int            done_q[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, accept_cyc = 0;
  bit mon_en = 1'b0, done_flag = 1'b0;
  int rdy_mode = 0, stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: DUT activity with no expectation queued (t=%0t)", name, $time);
  endtask

  // Reference model: whole-layer expectations from the grouping rules.
  task automatic push_layer(input int n, input int m, input int x, input int y, input int w, input bit chk_lat);
    int groups, len;
    logic [NU-1:0] mask;
    rd_t r;
    wr_t q;
    if (n == 0 || m == 0) begin
      done_q.push_back(chk_lat ? 1 : -1);
      return;
    end
    groups = (m + NU - 1) / NU;
    for (int g = 0; g < groups; g++) begin
      len  = (m - g * NU < NU) ? m - g * NU : NU;
      mask = NU'((1 << len) - 1);
      clr_q.push_back(mask);
      for (int i = 0; i < n; i++) begin
        r.xa = AW'(x + i);
        r.wa = AW'(w + g * n + i);
        r.m  = mask;
        rd_q.push_back(r);
      end
      for (int k = 0; k < len; k++) begin
        q.ya  = AW'(y + g * NU + k);
        q.sel = 2'(k);
        q.m   = mask;
        wr_q.push_back(q);
      end
    end
    done_q.push_back(chk_lat ? groups * (1 + n + AL) + m + 1 : -1);
  endtask

  // y_wr_ready driver: always ready, random, or a 3-cycle stall on lane 1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: y_wr_ready = 1'b1;
        1: y_wr_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (y_wr_en && out_sel == 2'd1 && stall_left > 0) begin
            y_wr_ready = 1'b0;
            stall_left--;
          end else begin
            y_wr_ready = 1'b1;
          end
        end
        default: y_wr_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT shows activity.
  initial begin
    bit prev_rd = 1'b0, st_prev = 1'b0, cc_pend = 1'b0;
    logic [1:0] st_sel = '0;
    logic [AW-1:0] st_addr = '0;
    int cc_exp = 0, lat, exp_lat;
    rd_t r;
    wr_t q;
    logic [NU-1:0] cm;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_rd = 1'b0; st_prev = 1'b0; cc_pend = 1'b0;
      end else begin
        chk("acc_en_delay", nu_acc_en, prev_rd);
        prev_rd = mem_rd_en;
        if (cc_pend) begin
`ifdef SEQ_PERF_CNT_EN
          chk("cycle_count", cycle_count, cc_exp);
`else
          chk("cycle_count_tied", cycle_count, 0);
`endif
          cc_pend = 1'b0;
        end
        if (st_prev) begin
          chk("stall_wr_en", y_wr_en, 1);
          chk("stall_out_sel", out_sel, st_sel);
          chk("stall_y_addr", y_wr_addr, st_addr);
        end
        if (nu_clear) begin
          if (clr_q.size() == 0) unexpected("nu_clear");
          else begin
            cm = clr_q.pop_front();
            chk("clear_mask", nu_mask, cm);
          end
        end
        if (mem_rd_en) begin
          if (rd_q.size() == 0) unexpected("mem_rd_en");
          else begin
            r = rd_q.pop_front();
            chk("xy_rd_addr", xy_rd_addr, r.xa);
            chk("w_rd_addr", w_rd_addr, r.wa);
            chk("rd_mask", nu_mask, r.m);
            chk("rd_busy", busy, 1);
          end
        end
        st_prev = 1'b0;
        if (y_wr_en) begin
          if (y_wr_ready) begin
            if (wr_q.size() == 0) unexpected("y_wr_en");
            else begin
              q = wr_q.pop_front();
              chk("y_wr_addr", y_wr_addr, q.ya);
              chk("out_sel", out_sel, q.sel);
              chk("wr_mask", nu_mask, q.m);
            end
          end else begin
            st_prev = 1'b1; st_sel = out_sel; st_addr = y_wr_addr;
          end
        end
        if (done) begin
          lat = cyc - accept_cyc + 1;
          chk("done_busy", busy, 1);
          if (done_q.size() == 0) unexpected("done");
          else begin
            exp_lat = done_q.pop_front();
            if (exp_lat >= 0) chk("done_latency", lat, exp_lat);
          end
          cc_exp = lat; cc_pend = 1'b1; done_flag = 1'b1;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_clear"}, nu_clear, 0);
    chk({tag, "_acc_en"}, nu_acc_en, 0);
    chk({tag, "_wr_en"}, y_wr_en, 0);
    chk({tag, "_mask"}, nu_mask, 0);
    chk({tag, "_out_sel"}, out_sel, 0);
    chk({tag, "_addrs"}, {8'd0, xy_rd_addr | w_rd_addr | y_wr_addr}, 0);
    chk({tag, "_count"}, cycle_count, 0);
  endtask

  task automatic run_layer(input int n, input int m, input int x, input int y, input int w,
                           input bit chk_lat, input bit inject);
    int t;
    push_layer(n, m, x, y, w, chk_lat);
    done_flag = 1'b0;
    in_count = AW'(n); out_count = AW'(m);
    x_base = AW'(x); y_base = AW'(y); w_base = AW'(w);
    start = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    start = 1'b0;
    in_count = AW'($urandom); out_count = AW'($urandom);
    x_base = AW'($urandom); y_base = AW'($urandom); w_base = AW'($urandom);
    if (inject) begin
      for (t = 0; t < 50 && !mem_rd_en; t++) begin
        @(posedge clk); #1;
      end
      chk("inject_reached_acc", mem_rd_en, 1);
      start = 1'b1; in_count = AW'(1); out_count = AW'(1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (t = 0; t < 3000 && !done_flag; t++) @(posedge clk);
    chk("done_seen", done_flag, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("clr_q_empty", clr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int t;
    #12;
    check_idle_outputs("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    run_layer(3, 4, 0, 0, 0, 1'b1, 1'b0);
    run_layer(2, 5, 10, 100, 0, 1'b1, 1'b0);
    rdy_mode = 2; stall_left = 3;
    run_layer(2, 4, 7, 40, 300, 1'b0, 1'b0);
    chk("stall_applied", stall_left, 0);
    rdy_mode = 0;
    run_layer(5, 3, 20, 30, 40, 1'b1, 1'b1);
    run_layer(0, 3, 1, 2, 3, 1'b1, 1'b0);
    run_layer(3, 0, 1, 2, 3, 1'b1, 1'b0);
    run_layer(4, 2, 12'hFFE, 12'hFFF, 12'hFFD, 1'b1, 1'b0);

    // Abandon a layer in WRITE with an asynchronous reset.
    mon_en = 1'b0;
    in_count = AW'(2); out_count = AW'(6); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (t = 0; t < 100 && !y_wr_en; t++) begin
      @(posedge clk); #1;
    end
    chk("reached_write", y_wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_layer(3, 6, 5, 9, 11, 1'b1, 1'b0);

    for (int k = 0; k < 14; k++) begin
      rdy_mode = (k % 2 == 0) ? 1 : 0;
      run_layer($urandom_range(0, 6), $urandom_range(0, 10), $urandom, $urandom, $urandom,
                rdy_mode == 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
